// File: rtl/prog_loader.sv
// Byte-stream program loader: MAGIC, LEN, data, CHECKSUM into the memory write port.
// Holds the CPU in reset until a checksum-verified image has been written.
module prog_loader #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter must hold 256 even when the address space is smaller.
  localparam int CW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        sum;

  logic              xfer;
  logic [7:0]        total;
  logic [CW-1:0]     len_val;

  assign in_ready = (state != S_RUN);
  assign xfer     = in_valid && in_ready;
  assign total    = sum + in_data;
  assign len_val  = (in_data == 8'h00) ? CW'(256) : CW'(in_data);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rstn  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (xfer) begin
        case (state)
          S_IDLE: begin
            if (in_data == MAGIC) begin
              state <= S_LEN;
              busy  <= 1'b1;
              err   <= 1'b0;
            end
          end
          S_LEN: begin
            state <= S_DATA;
            cnt   <= len_val;
            addr  <= '0;
            sum   <= '0;
          end
          S_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= in_data;
            addr      <= addr + ADDR_W'(1);
            sum       <= total;
            cnt       <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_CSUM;
          end
          S_CSUM: begin
            busy <= 1'b0;
            if (total == 8'h00) begin
              state    <= S_RUN;
              cpu_rstn <= 1'b1;
              done     <= 1'b1;
            end else begin
              state <= S_IDLE;
              err   <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus,
// popped and compared by a monitor on each mem_we cycle.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rstn;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  logic [15:0] sb[$];

  prog_loader #(.ADDR_W(8), .MAGIC(8'hA5)) dut (
    .clk(clk),
    .rstn(rstn),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rstn(cpu_rstn),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%02h data=%02h, no write expected",
                 mem_addr, mem_wdata);
      end else begin
        logic [15:0] exp;
        exp = sb.pop_front();
        if ({mem_addr, mem_wdata} !== exp) begin
          errors++;
          $display("FAIL write got addr=%02h data=%02h, expected addr=%02h data=%02h",
                   mem_addr, mem_wdata, exp[15:8], exp[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  // Sends a whole frame; data bytes get their expected writes queued.
  task automatic frame(input logic [7:0] len, input logic [7:0] d[], input logic [7:0] cs,
                       input int gap);
    send(8'hA5, gap);
    send(len, gap);
    for (int i = 0; i < d.size(); i++) begin
      sb.push_back({8'(i), d[i]});
      send(d[i], gap);
    end
    send(cs, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ok(input string name);
    chk({name, "_done"}, done, 1);
    chk({name, "_cpu_rstn"}, cpu_rstn, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_err"}, err, 0);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    logic [7:0] d3[];
    logic [7:0] d2[];
    logic [7:0] d18[];
    logic [7:0] d256[];
    d3   = '{8'h11, 8'h22, 8'h33};
    d2   = '{8'h88, 8'h89};
    d18  = '{8'h88, 8'h89, 8'h24, 8'h39, 8'h49, 8'h58, 8'h62, 8'h64, 8'h68,
             8'h81, 8'h89, 8'h6C, 8'h8E, 8'h71, 8'h89, 8'h75, 8'h00, 8'h00};
    d256 = new[256];
    for (int i = 0; i < 256; i++) d256[i] = 8'(i);

    in_data  = 8'h00;
    in_valid = 1'b0;
    rstn     = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rstn", cpu_rstn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    do_reset();

    // Basic load, back-to-back
    send(8'hA5, 0);
    chk("basic_busy_len", busy, 1);
    send(8'h03, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back({8'(i), d3[i]});
      send(d3[i], 0);
    end
    chk("basic_pre_cs_cpu_rstn", cpu_rstn, 0);
    chk("basic_pre_cs_done", done, 0);
    send(8'h9A, 0);
    chk_ok("basic");

    // Bad checksum then good frame
    do_reset();
    frame(8'h03, d3, 8'h9B, 0);
    chk("bad_err", err, 1);
    chk("bad_cpu_rstn", cpu_rstn, 0);
    chk("bad_done", done, 0);
    chk("bad_busy", busy, 0);
    chk("bad_in_ready", in_ready, 1);
    send(8'hA5, 0);
    chk("bad_err_cleared", err, 0);
    send(8'h03, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back({8'(i), d3[i]});
      send(d3[i], 0);
    end
    send(8'h9A, 0);
    chk_ok("retry");

    // Preamble and gaps
    do_reset();
    send(8'hFF, 3);
    send(8'h00, 3);
    chk("pre_busy", busy, 0);
    frame(8'h02, d2, 8'hEF, 3);
    chk_ok("gaps");

    // 18-byte image
    do_reset();
    frame(8'h12, d18, 8'h50, 0);
    chk_ok("img18");

    // LEN=0 means 256 bytes
    do_reset();
    frame(8'h00, d256, 8'h80, 0);
    chk_ok("len0");
    repeat (3) @(posedge clk);
    #1;
    chk("len0_in_ready_hold", in_ready, 0);
    chk("len0_done_hold", done, 1);

    // Reset mid-frame, after second data byte
    do_reset();
    send(8'hA5, 0);
    send(8'h03, 0);
    sb.push_back({8'h00, 8'h11});
    send(8'h11, 0);
    send(8'h22, 0);
    rstn = 1'b0;
    #1;
    sb.delete();
    chk("mid_in_ready", in_ready, 1);
    chk("mid_mem_we", mem_we, 0);
    chk("mid_mem_addr", mem_addr, 0);
    chk("mid_mem_wdata", mem_wdata, 0);
    chk("mid_cpu_rstn", cpu_rstn, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    frame(8'h03, d3, 8'h9A, 0);
    chk_ok("mid_resend");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
